// File: rtl/timer_dev_pkg.sv
// Shared constants for the countdown timer device: register map, CTRL layout,
// mode encodings and FSM state encoding.
package timer_dev_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

endpackage

// File: rtl/timer_dev_be_merge.sv
// Combinational byte-enable merge: each byte lane takes wdata when its enable
// is set, otherwise keeps the old value. Narrow registers use a partial lane.
module timer_dev_be_merge #(
  parameter int W = 32,
  localparam int NB = (W + 7) / 8
) (
  input  logic [W-1:0]  old_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [NB-1:0] be_i,
  output logic [W-1:0]  new_o
);

  always_comb begin
    new_o = old_i;
    for (int b = 0; b < W; b++) begin
      if (be_i[b / 8]) new_o[b] = wdata_i[b];
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Programmable countdown timer: CTRL/PRESET/COUNT register file on the bridge
// side, a four-state countdown FSM, and a maskable interrupt into HWInt.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter logic [3:0]  CTRL_RST   = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  tmr_state_e  state_q, state_d;
  logic        irq_flag_q, irq_flag_d;

  logic [3:0]  ctrl_wr_val;
  logic [31:0] preset_wr_val;
  logic        ctrl_wr, preset_wr;
  logic        en, mode_reload;
  logic        hw_en_clr, flag_set;

  assign ctrl_wr     = we && (addr == TMR_CTRL);
  assign preset_wr   = we && (addr == TMR_PRESET);
  assign en          = ctrl_q[CTRL_EN];
  assign mode_reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign irq         = ctrl_q[CTRL_IM] & irq_flag_q;

  timer_dev_be_merge #(.W(4)) u_ctrl_merge (
    .old_i   (ctrl_q),
    .wdata_i (wdata[3:0]),
    .be_i    (be[0]),
    .new_o   (ctrl_wr_val)
  );

  timer_dev_be_merge #(.W(32)) u_preset_merge (
    .old_i   (preset_q),
    .wdata_i (wdata),
    .be_i    (be),
    .new_o   (preset_wr_val)
  );

  always_comb begin
    rdata = 32'h0;
    case (addr)
      TMR_CTRL:   rdata = {28'h0, ctrl_q};
      TMR_PRESET: rdata = preset_q;
      TMR_COUNT:  rdata = count_q;
      default:    rdata = 32'h0;
    endcase
  end

  // Countdown FSM; LOAD samples the PRESET value from before any same-edge write.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hw_en_clr = 1'b0;
    flag_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        flag_set  = 1'b1;
        hw_en_clr = !mode_reload;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Software CTRL writes take priority over the hardware EN clear and flag set.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    irq_flag_d = irq_flag_q;
    if (hw_en_clr) ctrl_d[CTRL_EN] = 1'b0;
    if (flag_set) begin
      irq_flag_d = 1'b1;
    end else if (mode_reload) begin
      irq_flag_d = 1'b0;
    end
    if (ctrl_wr) begin
      ctrl_d     = ctrl_wr_val;
      irq_flag_d = 1'b0;
    end
    if (preset_wr) preset_d = preset_wr_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_RST;
      preset_q   <= PRESET_RST;
      count_q    <= 32'h0;
      state_q    <= ST_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed and randomized bench for timer_dev against a cycle-level
// behavioural model of the timer rules.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        we;
  logic [31:0] rdata;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  timer_dev dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .be    (be),
    .we    (we),
    .rdata (rdata),
    .irq   (irq)
  );

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_FIRE = 3;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  int          m_phase;
  logic        m_flag;

  function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input int a);
    case (a)
      0:       return {28'h0, m_ctrl};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl   = 4'b0000;
    m_preset = 32'h0;
    m_count  = 32'h0;
    m_phase  = PH_IDLE;
    m_flag   = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] b);
    logic [3:0]  nc;
    logic [31:0] np, nn, mc;
    int          nph;
    logic        nf, rel;
    nc = m_ctrl; np = m_preset; nn = m_count; nph = m_phase; nf = m_flag;
    rel = (m_ctrl[2:1] == 2'b01);
    if (m_phase == PH_IDLE) begin
      if (m_ctrl[0]) nph = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      nn = m_preset; nph = PH_RUN;
    end else if (m_phase == PH_RUN) begin
      if (!m_ctrl[0]) nph = PH_IDLE;
      else if (m_count > 1) nn = m_count - 1;
      else begin nn = 0; nph = PH_FIRE; end
    end else begin
      nf = 1'b1; nph = PH_IDLE;
      if (!rel) nc[0] = 1'b0;
    end
    if (rel && m_phase != PH_FIRE) nf = 1'b0;
    if (w && a == 2'd0) begin
      mc = merge_bytes({28'h0, m_ctrl}, d, b);
      nc = mc[3:0];
      nf = 1'b0;
    end
    if (w && a == 2'd1) np = merge_bytes(m_preset, d, b);
    m_ctrl = nc; m_preset = np; m_count = nn; m_phase = nph; m_flag = nf;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      addr = i[1:0];
      #1;
      check($sformatf("%s_rd%0d", tag, i), rdata, model_rdata(i));
    end
    check({tag, "_irq"}, {31'h0, irq}, {31'h0, m_ctrl[3] & m_flag});
  endtask

  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] b, input string tag);
    we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    model_edge(w, a, d, b);
    #1;
    we = 1'b0; be = 4'h0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 2'd0, 32'h0, 4'h0, tag);
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    int last, npulse;
    bit reached;
    rst_n = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0; be = 4'h0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // byte enables
    cyc(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, "pre_all");
    cyc(1'b1, 2'd1, 32'h1234_5678, 4'b0101, "pre_be");
    rd_check("pre_be_val", 2'd1, 32'hFF34_FF78);

    // one-shot
    cyc(1'b1, 2'd1, 32'd5, 4'hF, "os_pre");
    cyc(1'b1, 2'd0, 32'h9, 4'hF, "os_go");
    idle("os_load");
    for (int k = 5; k >= 0; k--) begin
      idle("os_run");
      rd_check("os_count", 2'd2, k);
      check("os_irq_low", {31'h0, irq}, 32'd0);
    end
    idle("os_fire");
    check("os_irq_high", {31'h0, irq}, 32'd1);
    rd_check("os_ctrl", 2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      idle("os_hold");
      check("os_irq_hold", {31'h0, irq}, 32'd1);
    end
    cyc(1'b1, 2'd0, 32'h0, 4'hF, "os_ack");
    check("os_irq_ack", {31'h0, irq}, 32'd0);

    // auto-reload
    cyc(1'b1, 2'd1, 32'd3, 4'hF, "ar_pre");
    cyc(1'b1, 2'd0, 32'hB, 4'hF, "ar_go");
    last = -1; npulse = 0;
    for (int c = 0; c < 36; c++) begin
      idle("ar_run");
      if (irq) begin
        if (last >= 0) check("ar_period", c - last, 32'd6);
        last = c;
        npulse++;
      end
    end
    check("ar_pulses", npulse, 32'd6);
    rd_check("ar_ctrl", 2'd0, 32'hB);
    cyc(1'b1, 2'd0, 32'h0, 4'hF, "ar_stop");

    // pause and restart
    cyc(1'b1, 2'd1, 32'd20, 4'hF, "pz_pre");
    cyc(1'b1, 2'd0, 32'h1, 4'hF, "pz_go");
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      idle("pz_run");
      if (m_phase == PH_RUN && m_count == 32'd8) reached = 1'b1;
    end
    check("pz_reach", {31'h0, reached}, 32'd1);
    cyc(1'b1, 2'd0, 32'h0, 4'hF, "pz_clr");
    for (int k = 0; k < 4; k++) idle("pz_hold");
    rd_check("pz_held", 2'd2, 32'd7);
    cyc(1'b1, 2'd0, 32'h1, 4'hF, "pz_set");
    idle("pz_idle");
    idle("pz_load");
    rd_check("pz_reload", 2'd2, 32'd20);
    idle("pz_cnt");
    cyc(1'b1, 2'd1, 32'd9, 4'hF, "pz_prewr");
    idle("pz_after");
    rd_check("pz_undisturbed", 2'd2, 32'd17);
    cyc(1'b1, 2'd0, 32'h0, 4'hF, "pz_stop");

    // masking
    cyc(1'b1, 2'd1, 32'd2, 4'hF, "mk_pre");
    cyc(1'b1, 2'd0, 32'h1, 4'hF, "mk_go");
    for (int k = 0; k < 7; k++) begin
      idle("mk_run");
      check("mk_irq_masked", {31'h0, irq}, 32'd0);
    end
    cyc(1'b1, 2'd0, 32'h8, 4'hF, "mk_im");

    // CTRL write on the INT edge
    cyc(1'b1, 2'd0, 32'h9, 4'hF, "rc_go");
    reached = 1'b0;
    for (int c = 0; c < 12 && !reached; c++) begin
      idle("rc_run");
      if (m_phase == PH_FIRE) reached = 1'b1;
    end
    check("rc_reach", {31'h0, reached}, 32'd1);
    cyc(1'b1, 2'd0, 32'h9, 4'hF, "rc_race");
    rd_check("rc_ctrl", 2'd0, 32'h9);
    check("rc_irq", {31'h0, irq}, 32'd0);
    idle("rc_load");
    idle("rc_cnt");
    rd_check("rc_reload", 2'd2, 32'd2);

    // reset mid-count, no clock edge
    cyc(1'b1, 2'd1, 32'hA5A5_0001, 4'hF, "rs_pre");
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      addr = i[1:0];
      #1;
      check("rs_async", rdata, 32'h0);
    end
    check("rs_irq", {31'h0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 200; c++) begin
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      logic [3:0]  b;
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      d = (a == 2'd1) ? $urandom_range(0, 6) : $urandom;
      b = 4'($urandom_range(0, 15));
      cyc(w, a, d, b, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
